// File: rtl/ula_pkg.sv
// Shared types for the ALU stage: op codes, FSM states and the flag bundle.
package ula_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpSlt = 3'b101,
    OpShl = 3'b110,
    OpMul = 3'b111
  } ula_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StHold = 2'b10
  } ula_state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } ula_flags_t;

endpackage

// File: rtl/ula_mul_seq.sv
// Sequential shift-add multiplier: start loads operands, one partial product per
// cycle, done_o high once Width iterations have been applied.
module ula_mul_seq #(
  parameter int unsigned Width = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [Width-1:0]   a_i,
  input  logic [Width-1:0]   b_i,
  output logic               done_o,
  output logic [2*Width-1:0] product_o
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic [2*Width-1:0] mcand_q, mcand_d;
  logic [2*Width-1:0] prod_q, prod_d;
  logic [Width-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;

  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = {{Width{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = CntW'(Width);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CntW'(1);
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign done_o    = busy_q && (cnt_q == '0);
  assign product_o = prod_q;

endmodule

// File: rtl/ula_stage.sv
// Registered ALU stage with valid/ready output handshake.
// Define ULA_MUL_EN to build the multi-cycle MUL; otherwise op 111 yields 0 in one cycle.
module ula_stage
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] w_SrcA,
  input  logic [WIDTH-1:0] w_SrcB,
  input  logic [2:0]       ula_control,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] w_ula_result,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned ShW = $clog2(WIDTH);

  ula_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  ula_flags_t       flags_q, flags_d;

  ula_op_t          op;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf;
  ula_flags_t       alu_flags;
  logic             accept;

  assign op        = ula_op_t'(ula_control);
  assign out_valid = (state_q == StHold);
  assign in_ready  = (state_q == StIdle) || ((state_q == StHold) && out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    sum       = {1'b0, w_SrcA} + {1'b0, w_SrcB};
    diff      = {1'b0, w_SrcA} - {1'b0, w_SrcB};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    unique case (op)
      OpAdd: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (w_SrcA[WIDTH-1] == w_SrcB[WIDTH-1]) && (sum[WIDTH-1] != w_SrcA[WIDTH-1]);
      end
      OpSub: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];  // borrow
        alu_ovf   = (w_SrcA[WIDTH-1] != w_SrcB[WIDTH-1]) && (diff[WIDTH-1] != w_SrcA[WIDTH-1]);
      end
      OpAnd: alu_res = w_SrcA & w_SrcB;
      OpOr:  alu_res = w_SrcA | w_SrcB;
      OpXor: alu_res = w_SrcA ^ w_SrcB;
      OpSlt: alu_res = {{(WIDTH-1){1'b0}}, $signed(w_SrcA) < $signed(w_SrcB)};
      OpShl: alu_res = w_SrcA << w_SrcB[ShW-1:0];
      OpMul: alu_res = '0;  // sequential path produces the real product when enabled
    endcase
    alu_flags = '{zero: (alu_res == '0), neg: alu_res[WIDTH-1], carry: alu_carry, ovf: alu_ovf};
  end

`ifdef ULA_MUL_EN
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  ula_mul_seq #(
    .Width (WIDTH)
  ) u_mul (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (mul_start),
    .a_i       (w_SrcA),
    .b_i       (w_SrcB),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef ULA_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      StIdle, StHold: begin
        if (accept) begin
`ifdef ULA_MUL_EN
          if (op == OpMul) begin
            mul_start = 1'b1;
            state_d   = StBusy;
          end else
`endif
          begin
            result_d = alu_res;
            flags_d  = alu_flags;
            state_d  = StHold;
          end
        end else if ((state_q == StHold) && out_ready) begin
          state_d = StIdle;
        end
      end
`ifdef ULA_MUL_EN
      StBusy: begin
        if (mul_done) begin
          result_d = mul_prod[WIDTH-1:0];
          flags_d  = '{zero:  (mul_prod[WIDTH-1:0] == '0),
                       neg:   mul_prod[WIDTH-1],
                       carry: (mul_prod[2*WIDTH-1:WIDTH] != '0),
                       ovf:   1'b0};
          state_d  = StHold;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign w_ula_result = result_q;
  assign flag_zero    = flags_q.zero;
  assign flag_neg     = flags_q.neg;
  assign flag_carry   = flags_q.carry;
  assign flag_ovf     = flags_q.ovf;

endmodule
